// File: rtl/byte_struct_packer.sv
// Packs two bytes into a 15-bit {x, y[13:0]} struct word with a Bool flag.
// Optional macro BSP_PARITY_EN adds a registered parity output.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/valid/ready   byte input handshake
//   out_word/valid/ready  packed word output handshake
//   out_nonzero           |out_word, registered with the word
//   trunc_count           saturating count of discarded byte1[7] == 1
//   out_parity            ^out_word (only with BSP_PARITY_EN)
module byte_struct_packer #(
  parameter int SWAP_LAYOUT = 0,
  parameter int TRUNC_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [14:0]        out_word,
  output logic               out_nonzero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TRUNC_W-1:0] trunc_count
`ifdef BSP_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } state_t;

  localparam logic [TRUNC_W-1:0] TRUNC_MAX = '1;
  localparam logic [TRUNC_W-1:0] TRUNC_ONE = TRUNC_W'(1);

  state_t      state;
  logic [7:0]  lo;
  logic        byte_hs;
  logic        word_hs;
  logic [14:0] raw;
  logic [14:0] laid;

  // Ready is forced low while reset is held so nothing
  // is taken during the reset cycle itself.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state)
        EMPTY:   in_ready = 1'b1;
        HALF:    in_ready = 1'b1;
        FULL:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign byte_hs = in_valid & in_ready;
  assign word_hs = out_valid & out_ready;

  // Range cast: byte1[7] does not fit in 15 bits.
  assign raw  = {in_data[6:0], lo};
  assign laid = (SWAP_LAYOUT != 0) ? {raw[13:0], raw[14]} : raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      lo          <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_nonzero <= 1'b0;
      trunc_count <= '0;
`ifdef BSP_PARITY_EN
      out_parity  <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (byte_hs) begin
            lo    <= in_data;
            state <= HALF;
          end
        end
        HALF: begin
          if (byte_hs) begin
            out_word    <= laid;
            out_nonzero <= |laid;
`ifdef BSP_PARITY_EN
            out_parity  <= ^laid;
`endif
            out_valid   <= 1'b1;
            state       <= FULL;
            if (in_data[7] && (trunc_count != TRUNC_MAX))
              trunc_count <= trunc_count + TRUNC_ONE;
          end
        end
        FULL: begin
          if (word_hs) begin
            out_valid <= 1'b0;
            // Drain and refill in the same cycle keeps 1 byte/cycle.
            if (byte_hs) begin
              lo    <= in_data;
              state <= HALF;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_struct_packer.sv
// Scoreboard bench for byte_struct_packer, both field layouts side by side.
// Directed scenarios first, then randomized traffic with random resets.
module tb_byte_struct_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic [14:0] word0, word1;
  logic        nz0, nz1;
  logic        ov0, ov1;
  logic [7:0]  tc0, tc1;
`ifdef BSP_PARITY_EN
  logic        par0, par1;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int raw;
    int trunc;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  bit m_full = 0;
  bit m_have = 0;
  int m_lo   = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  byte_struct_packer #(.SWAP_LAYOUT(0), .TRUNC_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_word(word0), .out_nonzero(nz0), .out_valid(ov0),
    .out_ready(out_ready), .trunc_count(tc0)
`ifdef BSP_PARITY_EN
    , .out_parity(par0)
`endif
  );

  byte_struct_packer #(.SWAP_LAYOUT(1), .TRUNC_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_word(word1), .out_nonzero(nz1), .out_valid(ov1),
    .out_ready(out_ready), .trunc_count(tc1)
`ifdef BSP_PARITY_EN
    , .out_parity(par1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int swapped(input int raw);
    return ((raw % 16384) * 2) + (raw / 16384);
  endfunction

  function automatic int ones(input int v);
    int n = 0;
    for (int i = 0; i < 15; i++) n += (v >> i) & 1;
    return n;
  endfunction

  // Monitor and reference model; all sampling on the falling edge.
  always @(negedge clk) begin
    automatic bit exp_rdy = rst_n && (!m_full || out_ready);
    automatic exp_t e;
    chk("in_ready0", int'(in_ready0), int'(exp_rdy));
    chk("in_ready1", int'(in_ready1), int'(exp_rdy));
    chk("out_valid0", int'(ov0), int'(m_full));
    chk("out_valid1", int'(ov1), int'(m_full));
    if (m_full && rst_n) begin
      if (exp_q.size() == 0) begin
        chk("queue_nonempty", 0, 1);
      end else begin
        e = exp_q[0];
        chk("word0", int'(word0), e.raw);
        chk("word1", int'(word1), swapped(e.raw));
        chk("nonzero0", int'(nz0), int'(e.raw != 0));
        chk("nonzero1", int'(nz1), int'(e.raw != 0));
        chk("trunc0", int'(tc0), e.trunc);
        chk("trunc1", int'(tc1), e.trunc);
`ifdef BSP_PARITY_EN
        chk("parity0", int'(par0), ones(e.raw) % 2);
        chk("parity1", int'(par1), ones(e.raw) % 2);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (!rst_n) begin
      m_full = 0;
      m_have = 0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      if (m_full && out_ready) m_full = 0;
      if (in_valid && exp_rdy) begin
        if (m_have) begin
          e.raw = (int'(in_data) % 128) * 256 + m_lo;
          if (in_data >= 8'd128) m_cnt++;
          e.trunc = (m_cnt > 255) ? 255 : m_cnt;
          exp_q.push_back(e);
          m_full = 1;
          m_have = 0;
        end else begin
          m_lo   = int'(in_data);
          m_have = 1;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with in_valid high
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_trunc", int'(tc0), 0);
    chk("rst_word", int'(word0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    sync();

    // 2: basic word, one cycle latency
    send(8'h34);
    send(8'h12);
    @(negedge clk);
    chk("t2_valid", int'(ov0), 1);
    chk("t2_word", int'(word0), 'h1234);
    chk("t2_nz", int'(nz0), 1);
    chk("t2_trunc", int'(tc0), 0);
    sync();

    // 3: dropped bit counted, zero word
    send(8'h00);
    send(8'h80);
    @(negedge clk);
    chk("t3_word", int'(word0), 0);
    chk("t3_nz", int'(nz0), 0);
    chk("t3_trunc", int'(tc0), 1);
    sync();

    // 4: alternate layout
    send(8'h01);
    send(8'h40);
    @(negedge clk);
    chk("t4_raw", int'(word0), 'h4001);
    chk("t4_swap", int'(word1), 'h0003);
    sync();

    // 5: backpressure then same-cycle drain and capture
    out_ready = 1'b0;
    send(8'h34);
    send(8'h12);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (10) begin
      @(negedge clk);
      chk("t5_in_ready", int'(in_ready0), 0);
      chk("t5_hold", int'(word0), 'h1234);
    end
    sync();
    out_ready = 1'b1;
    send(8'hAA);
    send(8'hBB);
    @(negedge clk);
    chk("t5_word", int'(word0), 'h3BAA);
    chk("t5_trunc", int'(tc0), 2);
    sync();

    // 6: mid-word reset, then saturation
    send(8'h55);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    send(8'h66);
    send(8'h07);
    @(negedge clk);
    chk("t6_word", int'(word0), 'h0766);
    chk("t6_trunc", int'(tc0), 0);
    sync();
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom));
      send(8'h80);
    end
    @(negedge clk);
    chk("t6_sat0", int'(tc0), 255);
    chk("t6_sat1", int'(tc1), 255);
    sync();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      rst_n     = ($urandom % 300) != 0;
      sync();
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) sync();
    @(negedge clk);
    chk("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
